// File: rtl/sifh_pkg.sv
// Shared constants for the successive-zoom dToF controller: default sizes,
// FSM state encoding and error codes.
package sifh_pkg;

    localparam int NP_DEF       = 16;
    localparam int NB_DEF       = 4;
    localparam int N_STAGES_DEF = 5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARM  = 3'd1;
    localparam logic [2:0] ST_ACQ  = 3'd2;
    localparam logic [2:0] ST_PEAK = 3'd3;
    localparam logic [2:0] ST_CALC = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_NOPEAK  = 2'b01,
        ERR_TIMEOUT = 2'b10
    } sifh_err_e;

endpackage

// File: rtl/sifh_zoom_controller_if.sv
// Handshake and window bus between the zoom controller (master) and the
// histogram / peak-detect datapath (slave).
interface sifh_zoom_controller_if #(
    parameter int NP = sifh_pkg::NP_DEF,
    parameter int NB = sifh_pkg::NB_DEF
);
    logic          histStart;
    logic          histDone;
    logic          peakDone;
    logic          peakValid;
    logic [NB-1:0] peakCH;
    logic [NP-1:0] thMinus;
    logic [NP-1:0] thPositive;

    modport master (
        output histStart, thMinus, thPositive,
        input  histDone, peakDone, peakValid, peakCH
    );

    modport slave (
        input  histStart, thMinus, thPositive,
        output histDone, peakDone, peakValid, peakCH
    );
endinterface

// File: rtl/sifh_window_calc.sv
// Combinational zoom-window arithmetic: stage centre, next (clamped) window
// bounds and next span shift from the current window origin, span and peak bin.
module sifh_window_calc
    import sifh_pkg::*;
#(
    parameter int NP       = NP_DEF,
    parameter int NB       = NB_DEF,
    parameter int N_STAGES = N_STAGES_DEF,
    parameter int SW       = $clog2(NP + 1)
) (
    input  logic [NP-1:0] lo,
    input  logic [SW-1:0] s,
    input  logic [NB-1:0] k,
    input  logic [2:0]    stage,
    output logic [NP-1:0] c,
    output logic [NP-1:0] loNext,
    output logic [NP-1:0] hiNext,
    output logic [SW-1:0] sNext,
    output logic          last
);
    localparam logic [SW-1:0] NB_S       = SW'(NB);
    localparam logic [SW-1:0] ONE_S      = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [NP+1:0] ONE_X      = {{(NP+1){1'b0}}, 1'b1};
    localparam logic [NP+1:0] FULL_X     = {2'b01, {NP{1'b0}}};
    localparam logic [2:0]    LAST_STAGE = 3'(N_STAGES - 1);

    logic [SW-1:0] wShift_s;
    logic [NP+1:0] binW_s, half_s, offs_s, base_s, center_s;
    logic [NP+1:0] loRaw_s, win2_s, loClamp_s, hiClamp_s;

    // Bin width, centre and slide-preserving clamp, all in NP+2 bits so
    // loRaw_s[NP+1] acts as the sign of the unclamped origin.
    always_comb begin
        wShift_s  = (s > NB_S) ? (s - NB_S) : {SW{1'b0}};
        binW_s    = ONE_X << wShift_s;
        half_s    = binW_s >> 1;
        offs_s    = {{(NP+2-NB){1'b0}}, k} * binW_s;
        base_s    = {2'b00, lo} + offs_s;
        center_s  = base_s + half_s;
        loRaw_s   = base_s - half_s;
        win2_s    = binW_s << 1;
        if (loRaw_s[NP+1]) begin
            loClamp_s = {(NP+2){1'b0}};
        end else if ((loRaw_s + win2_s) > FULL_X) begin
            loClamp_s = FULL_X - win2_s;
        end else begin
            loClamp_s = loRaw_s;
        end
        hiClamp_s = loClamp_s + win2_s - ONE_X;
        c         = center_s[NP-1:0];
        loNext    = loClamp_s[NP-1:0];
        hiNext    = hiClamp_s[NP-1:0];
        sNext     = s - NB_S + ONE_S;
        last      = (wShift_s == {SW{1'b0}}) || (stage == LAST_STAGE);
    end

endmodule

// File: rtl/sifh_zoom_controller.sv
// Successive-zoom dToF sequencer: arms the histogrammer per stage, narrows the
// window around each peak and reports the final time-of-flight.
// Optional per-stage watchdog: define SIFH_ZOOM_TIMEOUT_EN.
module sifh_zoom_controller
    import sifh_pkg::*;
#(
    parameter int NP             = NP_DEF,
    parameter int NB             = NB_DEF,
    parameter int N_STAGES       = N_STAGES_DEF,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    sifh_zoom_controller_if.master hist,
    output logic [2:0]            stageIdx,
    output logic                  busy,
    output logic [NP-1:0]         tof,
    output logic                  tofValid,
    output logic [1:0]            error
);
    localparam int SW = $clog2(NP + 1);

    logic [2:0]    state_r;
    logic [NP-1:0] lo_r, thMinus_r, thPositive_r, tof_r;
    logic [SW-1:0] shift_r;
    logic [NB-1:0] peakCh_r;
    logic [2:0]    stage_r;
    logic          histStart_r, busy_r, tofValid_r;
    logic [1:0]    error_r;

    logic [NP-1:0] center_s, loNext_s, hiNext_s;
    logic [SW-1:0] sNext_s;
    logic          last_s, timeout_s;

    sifh_window_calc #(.NP(NP), .NB(NB), .N_STAGES(N_STAGES), .SW(SW)) u_calc (
        .lo     (lo_r),
        .s      (shift_r),
        .k      (peakCh_r),
        .stage  (stage_r),
        .c      (center_s),
        .loNext (loNext_s),
        .hiNext (hiNext_s),
        .sNext  (sNext_s),
        .last   (last_s)
    );

`ifdef SIFH_ZOOM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wdCnt_r;

    // Per-stage watchdog: cleared when the stage is armed, counts while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdCnt_r <= {CW{1'b0}};
        end else if (state_r == ST_ARM) begin
            wdCnt_r <= {CW{1'b0}};
        end else if ((state_r == ST_ACQ) || (state_r == ST_PEAK)) begin
            wdCnt_r <= wdCnt_r + CW'(1);
        end else begin
            wdCnt_r <= wdCnt_r;
        end
    end

    assign timeout_s = ((state_r == ST_ACQ) || (state_r == ST_PEAK)) &&
                       (wdCnt_r == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unusedTimeout_s;
    assign unusedTimeout_s = (TIMEOUT_CYCLES != 32'sd0);
    assign timeout_s       = 1'b0;
`endif

    // Measurement FSM with all outputs registered; histStart is raised on the
    // transition into ARM so it is high exactly during the ARM cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            lo_r         <= {NP{1'b0}};
            shift_r      <= SW'(NP);
            peakCh_r     <= {NB{1'b0}};
            stage_r      <= 3'd0;
            thMinus_r    <= {NP{1'b0}};
            thPositive_r <= {NP{1'b1}};
            tof_r        <= {NP{1'b0}};
            histStart_r  <= 1'b0;
            busy_r       <= 1'b0;
            tofValid_r   <= 1'b0;
            error_r      <= ERR_NONE;
        end else begin
            histStart_r <= 1'b0;
            tofValid_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        error_r      <= ERR_NONE;
                        lo_r         <= {NP{1'b0}};
                        shift_r      <= SW'(NP);
                        stage_r      <= 3'd0;
                        thMinus_r    <= {NP{1'b0}};
                        thPositive_r <= {NP{1'b1}};
                        busy_r       <= 1'b1;
                        histStart_r  <= 1'b1;
                        state_r      <= ST_ARM;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARM: state_r <= ST_ACQ;
                ST_ACQ: begin
                    if (hist.histDone) begin
                        state_r <= ST_PEAK;
                    end else if (timeout_s) begin
                        error_r <= ERR_TIMEOUT;
                        busy_r  <= 1'b0;
                        state_r <= ST_ERR;
                    end else begin
                        state_r <= ST_ACQ;
                    end
                end
                ST_PEAK: begin
                    if (hist.peakDone && !hist.peakValid) begin
                        error_r <= ERR_NOPEAK;
                        busy_r  <= 1'b0;
                        state_r <= ST_ERR;
                    end else if (hist.peakDone) begin
                        peakCh_r <= hist.peakCH;
                        state_r  <= ST_CALC;
                    end else if (timeout_s) begin
                        error_r <= ERR_TIMEOUT;
                        busy_r  <= 1'b0;
                        state_r <= ST_ERR;
                    end else begin
                        state_r <= ST_PEAK;
                    end
                end
                ST_CALC: begin
                    if (last_s) begin
                        tof_r      <= center_s;
                        tofValid_r <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= ST_DONE;
                    end else begin
                        lo_r         <= loNext_s;
                        shift_r      <= sNext_s;
                        stage_r      <= stage_r + 3'd1;
                        thMinus_r    <= loNext_s;
                        thPositive_r <= hiNext_s;
                        histStart_r  <= 1'b1;
                        state_r      <= ST_ARM;
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                ST_ERR:  state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign hist.histStart  = histStart_r;
    assign hist.thMinus    = thMinus_r;
    assign hist.thPositive = thPositive_r;
    assign stageIdx        = stage_r;
    assign busy            = busy_r;
    assign tof             = tof_r;
    assign tofValid        = tofValid_r;
    assign error           = error_r;

endmodule

// File: tb/tb_sifh_zoom_controller.sv
// Directed + randomized bench for sifh_zoom_controller; expected windows and
// tof come from a window-bounds reference model (width/2^NB bins, clamp by slide).
module tb_sifh_zoom_controller;
    import sifh_pkg::*;

    localparam int NP  = 16;
    localparam int NB  = 4;
    localparam int NS  = 5;
    localparam int TMO = 100;
    localparam int FULL = (1 << NP);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    stageIdx;
    logic          busy;
    logic [NP-1:0] tof;
    logic          tofValid;
    logic [1:0]    error;

    sifh_zoom_controller_if #(.NP(NP), .NB(NB)) hif ();

    sifh_zoom_controller #(.NP(NP), .NB(NB), .N_STAGES(NS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .hist     (hif),
        .stageIdx (stageIdx),
        .busy     (busy),
        .tof      (tof),
        .tofValid (tofValid),
        .error    (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int kSeq[8];
    int mLo, mHi;
    int obsLo1, obsHi1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, ".histStart"}, hif.histStart, 0);
        check({tag, ".thMinus"}, hif.thMinus, 0);
        check({tag, ".thPositive"}, hif.thPositive, FULL - 1);
        check({tag, ".stageIdx"}, stageIdx, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".tof"}, tof, 0);
        check({tag, ".tofValid"}, tofValid, 0);
        check({tag, ".error"}, error, 0);
    endtask

    // One measurement; noPeakStage/abortStage = -1 disables that event.
    task automatic runMeas(input int noPeakStage, input int abortStage);
        int w, c, nl;
        bit last;
        mLo = 0;
        mHi = FULL - 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int st = 0; st < NS; st++) begin
            check("arm.histStart", hif.histStart, 1);
            check("arm.busy", busy, 1);
            check("arm.thMinus", hif.thMinus, mLo);
            check("arm.thPositive", hif.thPositive, mHi);
            check("arm.stageIdx", stageIdx, st);
            check("arm.error", error, ERR_NONE);
            check("arm.tofValid", tofValid, 0);
            if (st == 1) begin
                obsLo1 = hif.thMinus;
                obsHi1 = hif.thPositive;
            end
            hif.histDone = 1'b1;
            @(negedge clk);
            hif.histDone = 1'b0;
            check("acq.histStartPulse", hif.histStart, 0);
            if (st == abortStage) begin
                rst_n = 1'b0;
                #1;
                checkReset("midReset");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            hif.peakDone  = 1'b1;
            hif.peakValid = 1'b0;
            hif.peakCH    = NB'($urandom);
            @(negedge clk);
            hif.peakDone = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            hif.histDone = 1'b1;
            @(negedge clk);
            hif.histDone = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            hif.peakDone  = 1'b1;
            hif.peakValid = (st != noPeakStage);
            hif.peakCH    = NB'(kSeq[st]);
            @(negedge clk);
            hif.peakDone  = 1'b0;
            hif.peakValid = 1'b0;
            if (st == noPeakStage) begin
                check("noPeak.busy", busy, 0);
                check("noPeak.error", error, ERR_NOPEAK);
                check("noPeak.tofValid", tofValid, 0);
                check("noPeak.thMinus", hif.thMinus, mLo);
                check("noPeak.thPositive", hif.thPositive, mHi);
                @(negedge clk);
                check("noPeak.errorHeld", error, ERR_NOPEAK);
                check("noPeak.tofValid2", tofValid, 0);
                return;
            end
            w    = (mHi - mLo + 1) >> NB;
            c    = mLo + kSeq[st] * w + w / 2;
            last = (w == 1) || (st == NS - 1);
            @(negedge clk);
            if (last) begin
                check("done.tofValid", tofValid, 1);
                check("done.tof", tof, c);
                check("done.busy", busy, 0);
                check("done.thMinus", hif.thMinus, mLo);
                check("done.thPositive", hif.thPositive, mHi);
                @(negedge clk);
                check("done.tofValidOnce", tofValid, 0);
                check("done.tofHeld", tof, c);
                return;
            end
            nl = mLo + kSeq[st] * w - w / 2;
            if (nl < 0) nl = 0;
            if (nl + 2 * w - 1 > FULL - 1) nl = FULL - 2 * w;
            mLo = nl;
            mHi = nl + 2 * w - 1;
        end
        check("run.terminated", 0, 1);
    endtask

    task automatic randK();
        for (int i = 0; i < 8; i++) kSeq[i] = $urandom_range(0, 15);
    endtask

    initial begin
        hif.histDone  = 1'b0;
        hif.peakDone  = 1'b0;
        hif.peakValid = 1'b0;
        hif.peakCH    = '0;
        repeat (3) @(negedge clk);
        checkReset("reset");
        rst_n = 1'b1;

        // Nominal sequence of peak bins
        kSeq[0] = 5; kSeq[1] = 3; kSeq[2] = 8; kSeq[3] = 2; kSeq[4] = 7;
        runMeas(-1, -1);

        // Window clamped at the low end
        randK(); kSeq[0] = 0;
        runMeas(-1, -1);
        check("lowClamp.lo", obsLo1, 0);
        check("lowClamp.hi", obsHi1, 8191);

        // Window clamped at the high end
        randK(); kSeq[0] = 15;
        runMeas(-1, -1);
        check("highClamp.lo", obsLo1, 57344);
        check("highClamp.hi", obsHi1, 65535);

        // No peak at stage 2, then a clean run clears the error
        randK();
        runMeas(2, -1);
        randK();
        runMeas(-1, -1);

        // Reset during ACQ of stage 3, then a normal run
        randK();
        runMeas(-1, 3);
        randK();
        runMeas(-1, -1);

        for (int r = 0; r < 6; r++) begin
            randK();
            runMeas(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1, -1);
        end

        // Withheld histDone: stalls without the watchdog, times out with it
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (200) @(negedge clk);
`ifdef SIFH_ZOOM_TIMEOUT_EN
        check("stall.error", error, ERR_TIMEOUT);
        check("stall.busy", busy, 0);
`else
        check("stall.error", error, ERR_NONE);
        check("stall.busy", busy, 1);
        check("stall.stageIdx", stageIdx, 0);
`endif
        rst_n = 1'b0;
        #1;
        checkReset("finalReset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
